// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with valid/ready input.
// Frame: start(0), DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry circular input FIFO;
// otherwise a single holding register buffers one word.
module uart_tx_cfg #(
    parameter int unsigned BRCLOCK_CYCLES = 10,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_BITS-1:0]            s_data,
    input  logic                            pen,
    input  logic                            peven,
    input  logic                            stop2,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CW = $clog2(BRCLOCK_CYCLES);
    localparam int unsigned IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BRCLOCK_CYCLES - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_run;
    logic [CW-1:0]        r_baud;
    logic [IW-1:0]        r_bitidx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_pen;
    logic                 r_stop2;
    logic                 r_par;
    logic                 w_tick;
    logic                 w_stop_last;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_tx;
    logic [DATA_BITS-1:0] w_head;
    logic [LW-1:0]        w_level;

    assign w_tick      = (r_baud == BAUD_LAST);
    assign w_stop_last = !r_stop2 || (r_bitidx != '0);
    assign w_push      = s_valid && s_ready;

    // Ready is held low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_run <= 1'b0;
        else      r_run <= 1'b1;
    end

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [LW-1:0]        r_count;

    assign w_head  = r_mem[r_rptr];
    assign w_level = r_count;
    assign s_ready = r_run && (r_count < LW'(FIFO_DEPTH));

    // FIFO storage write; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= s_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_full;

    assign w_head  = r_hold;
    assign w_level = LW'(r_full);
    assign s_ready = r_run && !r_full;

    // Single holding register; push and pop are mutually exclusive here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else if (w_push) begin
            r_hold <= s_data;
            r_full <= 1'b1;
        end else if (w_pop) begin
            r_full <= 1'b0;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state, buffer pop and serial line value
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_tx   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_level != '0) begin
                    w_pop  = 1'b1;
                    w_next = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_tick) w_next = S_DATA;
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_tick && (r_bitidx == BIT_LAST)) w_next = r_pen ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                w_tx = r_par;
                if (w_tick) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_tick && w_stop_last) begin
                    if (w_level != '0) begin
                        w_pop  = 1'b1;
                        w_next = S_START;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Frame datapath: load on pop, baud counting, data shifting, stop-bit count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud   <= '0;
            r_bitidx <= '0;
            r_shift  <= '0;
            r_pen    <= 1'b0;
            r_stop2  <= 1'b0;
            r_par    <= 1'b0;
        end else if (w_pop) begin
            r_baud   <= '0;
            r_bitidx <= '0;
            r_shift  <= w_head;
            r_pen    <= pen;
            r_stop2  <= stop2;
            r_par    <= peven ? ^w_head : ~^w_head;
        end else if (r_state != S_IDLE) begin
            r_baud <= w_tick ? '0 : r_baud + CW'(1);
            if (w_tick) begin
                case (r_state)
                    S_DATA: begin
                        r_shift  <= {1'b0, r_shift[DATA_BITS-1:1]};
                        r_bitidx <= (r_bitidx == BIT_LAST) ? '0 : r_bitidx + IW'(1);
                    end
                    S_STOP: begin
                        if (!w_stop_last) r_bitidx <= IW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx    = w_tx;
    assign level = w_level;
    assign busy  = (r_state != S_IDLE) || (w_level != '0);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg (BRCLOCK_CYCLES=4, DATA_BITS=8, plus a 7-bit instance).
// Expected line activity comes from a bit-list model of the UART frame.
module tb_uart_tx_cfg;

    localparam int BR = 4;
`ifdef UART_TX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       pen = 1'b0, peven = 1'b0, stop2 = 1'b0;
    logic       tx, busy;
    logic [2:0] level;

    logic       s_valid7 = 1'b0;
    logic       s_ready7;
    logic [6:0] s_data7 = '0;
    logic       pen7 = 1'b0, peven7 = 1'b0, stop2_7 = 1'b0;
    logic       tx7, busy7;
    logic [2:0] level7;

    always #5 clk = ~clk;

    uart_tx_cfg #(.BRCLOCK_CYCLES(BR), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .pen(pen), .peven(peven), .stop2(stop2), .tx(tx), .busy(busy), .level(level)
    );

    uart_tx_cfg #(.BRCLOCK_CYCLES(BR), .DATA_BITS(7), .FIFO_DEPTH(4)) dut7 (
        .clk(clk), .rst(rst), .s_valid(s_valid7), .s_ready(s_ready7), .s_data(s_data7),
        .pen(pen7), .peven(peven7), .stop2(stop2_7), .tx(tx7), .busy(busy7), .level(level7)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int unsigned max_level;
    int unsigned rdy_bad;
    logic [7:0] src_q[$];
    logic [7:0] batch_q[$];

    typedef bit bitq_t[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: list of line levels, one per bit time
    function automatic bitq_t frame_bits(input logic [8:0] d, input int nb,
                                         input bit p_en, input bit p_even, input bit two);
        bitq_t q;
        int ones;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (p_en) q.push_back(p_even ? (ones % 2 == 1) : (ones % 2 == 0));
        q.push_back(1'b1);
        if (two) q.push_back(1'b1);
        return q;
    endfunction

    // One clock: retire a handshake, present the next queued word, watch level/ready
    task automatic step();
        logic fire;
        fire = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (fire) void'(src_q.pop_front());
        if (src_q.size() > 0) begin
            s_valid = 1'b1;
            s_data  = src_q[0];
        end else begin
            s_valid = 1'b0;
        end
        if (int'(level) > int'(max_level)) max_level = level;
        if (s_ready !== (int'(level) < CAP)) rdy_bad++;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d,
                               input bit p_en, input bit p_even, input bit two);
        bitq_t bits;
        logic [BR-1:0] obs;
        int busy_bad;
        bits = frame_bits({1'b0, d}, 8, p_en, p_even, two);
        busy_bad = 0;
        for (int i = 0; i < bits.size(); i++) begin
            for (int k = 0; k < BR; k++) begin
                obs[k] = tx;
                if (busy !== 1'b1) busy_bad++;
                step();
            end
            chk($sformatf("%s d=%02h bit%0d", tag, d, i), 64'(obs), bits[i] ? 64'hF : 64'h0);
        end
        chk($sformatf("%s d=%02h busy_in_frame", tag, d), 64'(busy_bad), 64'd0);
    endtask

    // Offer batch_q back-to-back from idle and check the continuous line output
    task automatic run_batch(input string tag, input bit p_en, input bit p_even,
                             input bit two, input bit flip);
        logic [7:0] exp_q[$];
        exp_q = batch_q;
        pen = p_en; peven = p_even; stop2 = two;
        max_level = 0;
        rdy_bad = 0;
        src_q = batch_q;
        s_valid = 1'b1;
        s_data = src_q[0];
        step();
        chk({tag, " accept_level"}, 64'(level), 64'd1);
        chk({tag, " accept_busy"}, 64'(busy), 64'd1);
        chk({tag, " accept_tx_idle"}, 64'(tx), 64'd1);
        step();
        chk({tag, " first_fall"}, 64'(tx), 64'd0);
        if (flip) begin
            pen = ~p_en; peven = ~p_even; stop2 = ~two;
        end
        foreach (exp_q[i]) check_frame(tag, exp_q[i], p_en, p_even, two);
        chk({tag, " end_busy"}, 64'(busy), 64'd0);
        chk({tag, " end_level"}, 64'(level), 64'd0);
        chk({tag, " end_tx"}, 64'(tx), 64'd1);
        chk({tag, " ready_vs_level"}, 64'(rdy_bad), 64'd0);
        if (exp_q.size() > CAP) chk({tag, " max_level"}, 64'(max_level), 64'(CAP));
        pen = p_en; peven = p_even; stop2 = two;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bitq_t b7;
        logic [BR-1:0] obs;
        bit rp, re, rs;

        // Reset held with s_valid asserted
        s_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst s_ready", 64'(s_ready), 64'd0);
        chk("rst tx", 64'(tx), 64'd1);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst level", 64'(level), 64'd0);
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("release s_ready", 64'(s_ready), 64'd1);
        chk("release busy", 64'(busy), 64'd0);

        batch_q = '{8'hA5};
        run_batch("a5_plain", 1'b0, 1'b0, 1'b0, 1'b0);
        run_batch("a5_even", 1'b1, 1'b1, 1'b0, 1'b0);
        run_batch("a5_odd", 1'b1, 1'b0, 1'b0, 1'b0);
        run_batch("a5_flip", 1'b1, 1'b1, 1'b1, 1'b1);

        batch_q = '{8'h55, 8'hAA};
        run_batch("b2b", 1'b0, 1'b0, 1'b0, 1'b0);

        batch_q = {};
        for (int i = 0; i < 6; i++) batch_q.push_back(8'($urandom));
        run_batch("six", 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);

        for (int n = 0; n < 4; n++) begin
            batch_q = {};
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) batch_q.push_back(8'($urandom));
            rp = 1'($urandom); re = 1'($urandom); rs = 1'($urandom);
            run_batch($sformatf("rnd%0d", n), rp, re, rs, 1'b0);
        end

        // Reset during data bit 3 of 0xFF
        pen = 1'b0; stop2 = 1'b0;
        src_q = '{8'hFF};
        s_valid = 1'b1;
        s_data = 8'hFF;
        step();
        step();
        repeat (BR + 3 * BR + 1) step();
        chk("pre_rst busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("midrst tx", 64'(tx), 64'd1);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst level", 64'(level), 64'd0);
        chk("midrst s_ready", 64'(s_ready), 64'd0);
        src_q = {};
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst s_ready", 64'(s_ready), 64'd1);
        chk("post_rst tx", 64'(tx), 64'd1);
        chk("post_rst busy", 64'(busy), 64'd0);
        batch_q = '{8'($urandom)};
        run_batch("post_rst", 1'b1, 1'($urandom), 1'b1, 1'b0);

        // DATA_BITS=7 instance: 0x0F with two stop bits
        chk("d7 s_ready", 64'(s_ready7), 64'd1);
        s_valid7 = 1'b1;
        s_data7 = 7'h0F;
        stop2_7 = 1'b1;
        @(posedge clk);
        #1;
        s_valid7 = 1'b0;
        chk("d7 accept_level", 64'(level7), 64'd1);
        @(posedge clk);
        #1;
        b7 = frame_bits(9'h00F, 7, 1'b0, 1'b0, 1'b1);
        chk("d7 frame_len", 64'(b7.size()), 64'd10);
        for (int i = 0; i < b7.size(); i++) begin
            for (int k = 0; k < BR; k++) begin
                obs[k] = tx7;
                @(posedge clk);
                #1;
            end
            chk($sformatf("d7 bit%0d", i), 64'(obs), b7[i] ? 64'hF : 64'h0);
        end
        chk("d7 end_busy", 64'(busy7), 64'd0);
        chk("d7 end_tx", 64'(tx7), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
